data_mem_arbiter: RTL and testbench

//  Shares the single-ported data memory between two requesters: port 0 (CPU load/store unit)
//  and port 1 (auxiliary master: debug loader / DMA). Owns the data memory's command port
//  (addr, write_data, memwrite, memread, sign_mask), sequences one access at a time by

---
 rtl/data_mem_arbiter_pkg.sv | 41 ++++
 rtl/data_mem_arbiter_rr_arb2.sv | 24 ++
 rtl/data_mem_arbiter.sv | 174 +++++++++++++++++
 tb/tb_data_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared widths, state/port encodings and the latched memory command type
// for the two-port data memory arbiter.
package data_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned NPORTS = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] sign_mask;
    } mem_cmd_t;

    function automatic mem_cmd_t make_cmd(
        input logic              we,
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] wdata,
        input logic [MASK_W-1:0] sign_mask
    );
        mem_cmd_t c;
        c.we        = we;
        c.addr      = addr;
        c.wdata     = wdata;
        c.sign_mask = sign_mask;
        return c;
    endfunction

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Combinational two-way picker: fixed priority to port 0 or alternate
// against the previous grant when both ports request.
module rr_arb2
    import data_mem_arbiter_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    input  logic fixed_prio_i,
    output logic grant_c_o,
    output logic grant_id_c_o
);

    always_comb begin
        grant_c_o    = req0_i | req1_i;
        grant_id_c_o = PORT_CPU;
        if (req0_i && req1_i) begin
            grant_id_c_o = fixed_prio_i ? PORT_CPU : ~last_grant_i;
        end else if (req1_i) begin
            grant_id_c_o = PORT_AUX;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the single-ported data memory between the CPU load/store unit (port 0)
// and an auxiliary master (port 1), one access at a time, tracking clk_stall.
module data_mem_arbiter
    import data_mem_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO = 0,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [MASK_W-1:0] p0_sign_mask,
    output logic              p0_ack,
    output logic              p0_err,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    input  logic [MASK_W-1:0] p1_sign_mask,
    output logic              p1_ack,
    output logic              p1_err,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_memwrite,
    output logic              mem_memread,
    output logic [MASK_W-1:0] mem_sign_mask,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_clk_stall,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e                   state_q,      state_d;
    mem_cmd_t                     cmd_q,        cmd_d;
    logic                         owner_q,      owner_d;
    logic                         last_grant_q, last_grant_d;
    logic                         seen_stall_q, seen_stall_d;
    logic [CNT_W-1:0]             cnt_q,        cnt_d;
    logic [NPORTS-1:0]            ack_q,        ack_d;
    logic [NPORTS-1:0]            err_q,        err_d;
    logic [NPORTS-1:0][DATA_W-1:0] rdata_q,     rdata_d;
    logic                         memread_q,    memread_d;
    logic                         memwrite_q,   memwrite_d;
    logic                         busy_q,       busy_d;

    logic                         grant_c;
    logic                         grant_id_c;
    logic                         fixed_prio_c;
    logic [CNT_W-1:0]             cnt_inc_c;
    mem_cmd_t                     req_cmd0_c;
    mem_cmd_t                     req_cmd1_c;

    assign fixed_prio_c = (FIXED_PRIO != 0);
    assign cnt_inc_c    = cnt_q + CNT_W'(1);
    assign req_cmd0_c   = make_cmd(p0_we, p0_addr, p0_wdata, p0_sign_mask);
    assign req_cmd1_c   = make_cmd(p1_we, p1_addr, p1_wdata, p1_sign_mask);

    rr_arb2 u_rr_arb2 (
        .req0_i       (p0_req),
        .req1_i       (p1_req),
        .last_grant_i (last_grant_q),
        .fixed_prio_i (fixed_prio_c),
        .grant_c_o    (grant_c),
        .grant_id_c_o (grant_id_c)
    );

    // Next-state and registered-output computation.
    always_comb begin
        state_d      = state_q;
        cmd_d        = cmd_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        seen_stall_d = seen_stall_q;
        cnt_d        = cnt_q;
        ack_d        = '0;
        err_d        = '0;
        rdata_d      = rdata_q;
        memread_d    = 1'b0;
        memwrite_d   = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                // Hold off while the memory is still finishing an orphaned access.
                if (!mem_clk_stall && grant_c) begin
                    state_d      = ARB_ISSUE;
                    owner_d      = grant_id_c;
                    last_grant_d = grant_id_c;
                    cmd_d        = (grant_id_c == PORT_AUX) ? req_cmd1_c : req_cmd0_c;
                    memread_d    = ~cmd_d.we;
                    memwrite_d   = cmd_d.we;
                end
            end
            ARB_ISSUE: begin
                state_d = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (mem_clk_stall) begin
                    seen_stall_d = 1'b1;
                end
                if (seen_stall_q && !mem_clk_stall) begin
                    state_d           = ARB_RESP;
                    ack_d[owner_q]    = 1'b1;
                    rdata_d[owner_q]  = cmd_q.we ? '0 : mem_rdata;
                end else if (cnt_inc_c == CNT_W'(TIMEOUT)) begin
                    state_d           = ARB_RESP;
                    ack_d[owner_q]    = 1'b1;
                    err_d[owner_q]    = 1'b1;
                    rdata_d[owner_q]  = '0;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ARB_RESP: begin
                state_d      = ARB_IDLE;
                seen_stall_d = 1'b0;
                cnt_d        = '0;
            end
        endcase

        busy_d = (state_d != ARB_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARB_IDLE;
            cmd_q        <= '0;
            owner_q      <= PORT_CPU;
            last_grant_q <= PORT_AUX;
            seen_stall_q <= 1'b0;
            cnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
            memread_q    <= 1'b0;
            memwrite_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            seen_stall_q <= seen_stall_d;
            cnt_q        <= cnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
            memread_q    <= memread_d;
            memwrite_q   <= memwrite_d;
            busy_q       <= busy_d;
        end
    end

    assign p0_ack        = ack_q[0];
    assign p0_err        = err_q[0];
    assign p0_rdata      = rdata_q[0];
    assign p1_ack        = ack_q[1];
    assign p1_err        = err_q[1];
    assign p1_rdata      = rdata_q[1];
    assign mem_addr      = cmd_q.addr;
    assign mem_wdata     = cmd_q.wdata;
    assign mem_sign_mask = cmd_q.sign_mask;
    assign mem_memread   = memread_q;
    assign mem_memwrite  = memwrite_q;
    assign busy          = busy_q;
    assign owner         = owner_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: two instances (round-robin/TIMEOUT=64 and
// fixed-priority/TIMEOUT=8), each driving a small behavioural data memory.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_r   [2][2];
    logic        we_r    [2][2];
    logic [31:0] addr_r  [2][2];
    logic [31:0] wdata_r [2][2];
    logic [3:0]  sm_r    [2][2];
    logic        ack_w   [2][2];
    logic        err_w   [2][2];
    logic [31:0] rdata_w [2][2];

    logic [31:0] mem_addr_w  [2];
    logic [31:0] mem_wdata_w [2];
    logic        memwrite_w  [2];
    logic        memread_w   [2];
    logic [3:0]  mem_sm_w    [2];
    logic [31:0] mem_rdata_w [2];
    logic        mem_stall_w [2];
    logic        busy_w      [2];
    logic        owner_w     [2];
    int          nstrobe_w   [2];
    int          nviol_w     [2];
    logic [7:0]  led_w       [2];

    logic        stub_r    [2];
    logic        bd_we_r   [2];
    logic [31:0] bd_addr_r [2];
    logic [31:0] bd_data_r [2];

    int n_vec = 0;
    int n_err = 0;
    int order[$];

    // sign_mask model: [1:0] 0=byte 1=half else word; [2] set = zero-extend.
    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [1:0] off, input logic [3:0] sm);
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        int          hs;
        sh = 8 * int'(off);
        hs = 16 * int'(off[1]);
        b  = w[sh +: 8];
        h  = w[hs +: 16];
        case (sm[1:0])
            2'd0:    return sm[2] ? {24'h0, b} : {{24{b[7]}}, b};
            2'd1:    return sm[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] w, input logic [1:0] off, input logic [31:0] d, input logic [3:0] sm);
        logic [31:0] r;
        int          sh;
        int          hs;
        sh = 8 * int'(off);
        hs = 16 * int'(off[1]);
        r  = w;
        case (sm[1:0])
            2'd0:    r[sh +: 8]  = d[7:0];
            2'd1:    r[hs +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        data_mem_arbiter #(
            .FIXED_PRIO (g),
            .TIMEOUT    ((g == 0) ? 64 : 8)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .p0_req        (req_r[g][0]),
            .p0_we         (we_r[g][0]),
            .p0_addr       (addr_r[g][0]),
            .p0_wdata      (wdata_r[g][0]),
            .p0_sign_mask  (sm_r[g][0]),
            .p0_ack        (ack_w[g][0]),
            .p0_err        (err_w[g][0]),
            .p0_rdata      (rdata_w[g][0]),
            .p1_req        (req_r[g][1]),
            .p1_we         (we_r[g][1]),
            .p1_addr       (addr_r[g][1]),
            .p1_wdata      (wdata_r[g][1]),
            .p1_sign_mask  (sm_r[g][1]),
            .p1_ack        (ack_w[g][1]),
            .p1_err        (err_w[g][1]),
            .p1_rdata      (rdata_w[g][1]),
            .mem_addr      (mem_addr_w[g]),
            .mem_wdata     (mem_wdata_w[g]),
            .mem_memwrite  (memwrite_w[g]),
            .mem_memread   (memread_w[g]),
            .mem_sign_mask (mem_sm_w[g]),
            .mem_rdata     (mem_rdata_w[g]),
            .mem_clk_stall (mem_stall_w[g]),
            .busy          (busy_w[g]),
            .owner         (owner_w[g])
        );

        // Memory: stall high two cycles after a strobe, access completes as stall falls; never reset.
        logic [31:0] words [4096];
        logic        stall_q    = 1'b0;
        logic        cnt_q      = 1'b0;
        logic        pend_we    = 1'b0;
        logic [31:0] pend_addr  = '0;
        logic [31:0] pend_wdata = '0;
        logic [3:0]  pend_sm    = '0;
        logic [31:0] rdata_q    = '0;
        logic [7:0]  led_q      = '0;
        int          nstrobe_q  = 0;
        int          nviol_q    = 0;

        always @(posedge clk) begin
            if (bd_we_r[g]) words[bd_addr_r[g][13:2]] <= bd_data_r[g];
            if (memread_w[g] || memwrite_w[g]) begin
                nstrobe_q <= nstrobe_q + 1;
                if (stall_q) nviol_q <= nviol_q + 1;
                if (!stub_r[g]) begin
                    stall_q    <= 1'b1;
                    cnt_q      <= 1'b1;
                    pend_we    <= memwrite_w[g];
                    pend_addr  <= mem_addr_w[g];
                    pend_wdata <= mem_wdata_w[g];
                    pend_sm    <= mem_sm_w[g];
                end
            end else if (stall_q) begin
                if (cnt_q) begin
                    cnt_q <= 1'b0;
                end else begin
                    stall_q <= 1'b0;
                    if (pend_we) begin
                        words[pend_addr[13:2]] <= store_merge(words[pend_addr[13:2]], pend_addr[1:0], pend_wdata, pend_sm);
                        if (pend_addr == 32'h0000_2000) led_q <= pend_wdata[7:0];
                    end else begin
                        rdata_q <= load_val(words[pend_addr[13:2]], pend_addr[1:0], pend_sm);
                    end
                end
            end
        end

        assign mem_stall_w[g] = stall_q;
        assign mem_rdata_w[g] = rdata_q;
        assign nstrobe_w[g]   = nstrobe_q;
        assign nviol_w[g]     = nviol_q;
        assign led_w[g]       = led_q;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic request(input int d, input int p, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm);
        @(posedge clk);
        #1;
        req_r[d][p]   = 1'b1;
        we_r[d][p]    = we;
        addr_r[d][p]  = a;
        wdata_r[d][p] = wd;
        sm_r[d][p]    = sm;
    endtask

    task automatic wait_ack(input int d, input int p, output int cyc, output logic [31:0] rd, output logic er, output int strb);
        cyc  = -1;
        strb = 0;
        rd   = '0;
        er   = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (memread_w[d] || memwrite_w[d]) strb++;
            if (ack_w[d][p]) begin
                cyc = i;
                rd  = rdata_w[d][p];
                er  = err_w[d][p];
                break;
            end
        end
    endtask

    task automatic access(input int d, input int p, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] sm,
                          output int cyc, output logic [31:0] rd, output logic er, output int strb);
        request(d, p, we, a, wd, sm);
        wait_ack(d, p, cyc, rd, er, strb);
        req_r[d][p] = 1'b0;
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic contend(input int d);
        order.delete();
        fork
            begin : br_p0
                int c0; logic [31:0] r0; logic e0; int s0;
                for (int k = 0; k < 4; k++) begin
                    access(d, 0, 1'b0, 32'h0000_1010, 32'h0, 4'h2, c0, r0, e0, s0);
                    if (c0 > 0) order.push_back(0);
                end
            end
            begin : br_p1
                int c1; logic [31:0] r1; logic e1; int s1;
                for (int k = 0; k < 4; k++) begin
                    access(d, 1, 1'b0, 32'h0000_1010, 32'h0, 4'h2, c1, r1, e1, s1);
                    if (c1 > 0) order.push_back(1);
                end
            end
        join
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          c;
        int          s;
        logic [31:0] rd;
        logic        er;
        int          s0;
        int          v0;

        for (int d = 0; d < 2; d++) begin
            stub_r[d]    = 1'b0;
            bd_we_r[d]   = 1'b0;
            bd_addr_r[d] = '0;
            bd_data_r[d] = '0;
            for (int p = 0; p < 2; p++) begin
                req_r[d][p]   = 1'b0;
                we_r[d][p]    = 1'b0;
                addr_r[d][p]  = '0;
                wdata_r[d][p] = '0;
                sm_r[d][p]    = '0;
            end
        end

        // Reset state.
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",     32'(busy_w[0]),    32'h0);
        check("rst_owner",    32'(owner_w[0]),   32'h0);
        check("rst_mem_addr", mem_addr_w[0],     32'h0);
        check("rst_memread",  32'(memread_w[0]), 32'h0);
        check("rst_p0_ack",   32'(ack_w[0][0]),  32'h0);
        rst_n = 1'b1;

        for (int d = 0; d < 2; d++) begin
            bd_we_r[d]   = 1'b1;
            bd_addr_r[d] = 32'h0000_1010;
            bd_data_r[d] = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) bd_we_r[d] = 1'b0;

        // p0 word load.
        access(0, 0, 1'b0, 32'h0000_1010, 32'h0, 4'h2, c, rd, er, s);
        check("ld_latency", 32'(c),         32'd5);
        check("ld_rdata",   rd,             32'hDEAD_BEEF);
        check("ld_err",     32'(er),        32'h0);
        check("ld_strobes", 32'(s),         32'd1);
        check("ld_owner",   32'(owner_w[0]), 32'h0);

        // p1 byte store then word load.
        access(0, 1, 1'b1, 32'h0000_1013, 32'h0000_00A5, 4'h0, c, rd, er, s);
        check("sb_latency", 32'(c),  32'd5);
        check("sb_rdata",   rd,      32'h0);
        check("sb_err",     32'(er), 32'h0);
        access(0, 1, 1'b0, 32'h0000_1010, 32'h0, 4'h2, c, rd, er, s);
        check("lw_rdata",   rd,              32'hA5AD_BEEF);
        check("lw_owner",   32'(owner_w[0]), 32'h1);
        check("lw_p0_ack",  32'(ack_w[0][0]), 32'h0);

        // Round-robin contention.
        reset_pulse();
        contend(0);
        check("rr_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("rr_grant%0d", i), 32'((i < order.size()) ? order[i] : 99), 32'(i % 2));

        // Fixed-priority contention.
        reset_pulse();
        contend(1);
        check("fp_count", 32'(order.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            check($sformatf("fp_grant%0d", i), 32'((i < order.size()) ? order[i] : 99), 32'((i < 4) ? 0 : 1));

        // Timeout with a memory that never stalls.
        stub_r[1] = 1'b1;
        access(1, 0, 1'b0, 32'h0000_1010, 32'h0, 4'h2, c, rd, er, s);
        stub_r[1] = 1'b0;
        check("to_latency", 32'(c),  32'd10);
        check("to_err",     32'(er), 32'h1);
        check("to_rdata",   rd,      32'h0);

        // LED store.
        access(0, 0, 1'b1, 32'h0000_2000, 32'h0000_00FF, 4'h2, c, rd, er, s);
        check("led_latency", 32'(c),     32'd5);
        check("led_rdata",   rd,         32'h0);
        check("led_err",     32'(er),    32'h0);
        check("led_value",   32'(led_w[0]), 32'h0000_00FF);

        // Reset one cycle after ISSUE while the memory is mid-access.
        s0 = nstrobe_w[0];
        v0 = nviol_w[0];
        request(0, 0, 1'b0, 32'h0000_1010, 32'h0, 4'h2);
        @(posedge clk);
        #1;
        check("rm_issue", 32'(memread_w[0]), 32'h1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rm_busy",     32'(busy_w[0]),    32'h0);
        check("rm_memread",  32'(memread_w[0]), 32'h0);
        check("rm_mem_addr", mem_addr_w[0],     32'h0);
        check("rm_p0_ack",   32'(ack_w[0][0]),  32'h0);
        #1;
        rst_n = 1'b1;
        wait_ack(0, 0, c, rd, er, s);
        req_r[0][0] = 1'b0;
        check("rm_latency", 32'(c),                 32'd7);
        check("rm_rdata",   rd,                     32'hA5AD_BEEF);
        check("rm_strobes", 32'(nstrobe_w[0] - s0), 32'd2);
        check("rm_overlap", 32'(nviol_w[0] - v0),   32'd0);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
